// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator: op codes, FSM states and
// range/saturation helpers working on a wide signed intermediate.
package acc_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_CLR  = 3'b100;
  localparam logic [2:0] OP_MAC  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_ACCUM = 2'd2
  } state_e;

  // Wide enough for a 2*DATASIZE+1 bit MAC sum with DATASIZE up to 32.
  localparam int WIDE_W = 66;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic logic fits_signed(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return (v <= hi) && (v >= lo);
  endfunction

  // Clamp to the w-bit signed range when sat is set; otherwise pass through
  // so the caller's truncation gives the wrapped result.
  function automatic wide_t sat_result(input wide_t v, input int unsigned w, input logic sat);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (!sat || fits_signed(v, w)) return v;
    return (v > hi) ? hi : lo;
  endfunction

endpackage

// File: rtl/acc_mul_seq.sv
// Signed shift-add multiplier: one partial product per cycle over W cycles,
// exact 2*W-bit result; the sign bit of the multiplier is subtracted.
module acc_mul_seq #(
  parameter int W = 16
) (
  input  logic           clock_i,
  input  logic           nreset_i,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] product_o,
  output logic           last_o,
  output logic           valid_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplr_q, mplr_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d;

  always_comb begin
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      mcand_d = {{W{a_i[W-1]}}, a_i};
      mplr_d  = b_i;
      prod_d  = '0;
      cnt_d   = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      if (cnt_q < CW'(W)) begin
        if (mplr_q[0]) begin
          prod_d = (cnt_q == CW'(W - 1)) ? prod_q - mcand_q : prod_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  assign product_o = prod_q;
  assign last_o    = run_q && (cnt_q == CW'(W - 1));
  assign valid_o   = run_q && (cnt_q == CW'(W));

endmodule

// File: rtl/acc_mac.sv
// Working accumulator with load/add/sub/clear and an iterative
// multiply-accumulate; optional saturation and sticky overflow.
module acc_mac
  import acc_pkg::*;
#(
  parameter int unsigned DATASIZE = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clock_i,
  input  logic                nreset_i,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [DATASIZE-1:0] data_i,
  input  logic [DATASIZE-1:0] coef_i,
  input  logic                abort_i,
  output logic [DATASIZE-1:0] data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                zero_o,
  output logic                neg_o,
  output logic                ovf_o
);

  localparam int PW = 2 * DATASIZE;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;

  logic                mul_start, mul_abort, mul_last, mul_valid;
  logic [PW-1:0]       mul_product;

  wide_t               acc_w, data_w, prod_w;
  wide_t               wb_sum, wb_val;
  logic                wb_en;

  assign acc_w  = wide_t'($signed(acc_q));
  assign data_w = wide_t'($signed(data_i));
  assign prod_w = wide_t'($signed(mul_product));

  // The multiplier only listens to abort while a MAC is actually in flight.
  assign mul_abort = abort_i && (state_q != ST_IDLE);

  acc_mul_seq #(
    .W (DATASIZE)
  ) u_mul (
    .clock_i   (clock_i),
    .nreset_i  (nreset_i),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .a_i       (data_i),
    .b_i       (coef_i),
    .product_o (mul_product),
    .last_o    (mul_last),
    .valid_o   (mul_valid)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    wb_en     = 1'b0;
    wb_sum    = '0;
    wb_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          done_d = 1'b1;
          case (op_i)
            OP_LOAD: begin
              acc_d = data_i;
              ovf_d = 1'b0;
            end
            OP_ADD: begin
              wb_en  = 1'b1;
              wb_sum = acc_w + data_w;
            end
            OP_SUB: begin
              wb_en  = 1'b1;
              wb_sum = acc_w - data_w;
            end
            OP_CLR: begin
              acc_d = '0;
              ovf_d = 1'b0;
            end
            OP_MAC: begin
              done_d    = 1'b0;
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (abort_i)       state_d = ST_IDLE;
        else if (mul_last) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (mul_valid) begin
          wb_en   = 1'b1;
          wb_sum  = acc_w + prod_w;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wb_en) begin
      wb_val = sat_result(wb_sum, DATASIZE, SATURATE);
      acc_d  = wb_val[DATASIZE-1:0];
      if (!fits_signed(wb_sum, DATASIZE)) ovf_d = 1'b1;
    end
    zero_d = (acc_d == '0);
    neg_d  = acc_d[DATASIZE-1];
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign data_o = acc_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign zero_o = zero_q;
  assign neg_o  = neg_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_acc_mac.sv
// Randomised and directed checks of acc_mac (saturating and wrapping builds)
// against an integer reference model.
module tb_acc_mac;

  localparam int N = 16;
  localparam logic [2:0] NOP = 3'b000, LOAD = 3'b001, ADD = 3'b010,
                         SUB = 3'b011, CLR = 3'b100, MAC = 3'b101;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [N-1:0] din = '0;
  logic [N-1:0] coef = '0;

  logic [N-1:0] data_s, data_w;
  logic         busy_s, done_s, zero_s, neg_s, ovf_s;
  logic         busy_w, done_w, zero_w, neg_w, ovf_w;
  logic [20:0]  obs [2];

  int tests_run = 0;
  int tests_failed = 0;

  longint m_acc [2];
  bit     m_ovf [2];

  always #5 clk = ~clk;

  acc_mac #(.DATASIZE(N), .SATURATE(1'b1)) dut_sat (
    .clock_i(clk), .nreset_i(nreset), .start_i(start), .op_i(op),
    .data_i(din), .coef_i(coef), .abort_i(abort),
    .data_o(data_s), .busy_o(busy_s), .done_o(done_s),
    .zero_o(zero_s), .neg_o(neg_s), .ovf_o(ovf_s));

  acc_mac #(.DATASIZE(N), .SATURATE(1'b0)) dut_wrap (
    .clock_i(clk), .nreset_i(nreset), .start_i(start), .op_i(op),
    .data_i(din), .coef_i(coef), .abort_i(abort),
    .data_o(data_w), .busy_o(busy_w), .done_o(done_w),
    .zero_o(zero_w), .neg_o(neg_w), .ovf_o(ovf_w));

  assign obs[0] = {data_s, zero_s, neg_s, ovf_s, busy_s, done_s};
  assign obs[1] = {data_w, zero_w, neg_w, ovf_w, busy_w, done_w};

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [N-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [20:0] exp_vec(input int k, input logic busy, input logic done);
    logic [N-1:0] d;
    d = m_acc[k][N-1:0];
    return {d, m_acc[k] == 0, m_acc[k] < 0, m_ovf[k], busy, done};
  endfunction

  task automatic m_write(input int k, input longint r);
    longint t;
    if (r > 32767 || r < -32768) begin
      m_ovf[k] = 1'b1;
      if (k == 0) begin
        m_acc[k] = (r > 0) ? 64'sd32767 : -64'sd32768;
      end else begin
        t = r;
        m_acc[k] = sx(t[N-1:0]);
      end
    end else begin
      m_acc[k] = r;
    end
  endtask

  task automatic m_op(input logic [2:0] o, input logic [N-1:0] d, input logic [N-1:0] c);
    for (int k = 0; k < 2; k++) begin
      case (o)
        LOAD: begin m_acc[k] = sx(d); m_ovf[k] = 1'b0; end
        ADD:  m_write(k, m_acc[k] + sx(d));
        SUB:  m_write(k, m_acc[k] - sx(d));
        CLR:  begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        MAC:  m_write(k, m_acc[k] + sx(d) * sx(c));
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [N-1:0] d);
    op = o; din = d; start = 1'b1;
    tick();
    start = 1'b0;
    m_op(o, d, '0);
  endtask

  // Returns how many sampled cycles showed busy and at which sample done appeared
  // (sample 0 is taken right after the start edge).
  task automatic issue_mac(input logic [N-1:0] d, input logic [N-1:0] c,
                           output int busy_cnt, output int done_at, output int done_cnt);
    op = MAC; din = d; coef = c; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_at = -1; done_cnt = 0;
    for (int j = 0; j < 24; j++) begin
      if (busy_s) busy_cnt++;
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j < 23) tick();
    end
    m_op(MAC, d, c);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    m_reset();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== 21'h00010) begin
        tests_failed++;
        $display("FAIL reset dut%0d got %h expected %h", k, obs[k], 21'h00010);
      end
    end
    nreset = 1'b1;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_load();
    issue(LOAD, 16'h1234);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== exp_vec(k, 1'b0, 1'b1)) begin
        tests_failed++;
        $display("FAIL load_1234 dut%0d got %h expected %h", k, obs[k], exp_vec(k, 1'b0, 1'b1));
      end
    end
    // start_i low: nothing may change and done must drop
    op = ADD; din = 16'h0005;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== exp_vec(k, 1'b0, 1'b0)) begin
        tests_failed++;
        $display("FAIL idle_hold dut%0d got %h expected %h", k, obs[k], exp_vec(k, 1'b0, 1'b0));
      end
    end
    issue(3'b110, 16'h0F0F);
    tests_run++;
    if (obs[0] !== exp_vec(0, 1'b0, 1'b1)) begin
      tests_failed++;
      $display("FAIL nop_11x got %h expected %h", obs[0], exp_vec(0, 1'b0, 1'b1));
    end
    $display("[TB] load/idle/nop done, data=%h", data_s);
  endtask

  task automatic test_overflow();
    issue(LOAD, 16'h7FFF);
    issue(ADD, 16'h0001);
    tests_run++;
    if (obs[0] !== {16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_sat got %h expected %h", obs[0], {16'h7FFF, 5'b00101});
    end
    tests_run++;
    if (obs[1] !== {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_wrap got %h expected %h", obs[1], {16'h8000, 5'b01101});
    end
    issue(CLR, 16'h0000);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL clr dut%0d got %h expected %h", k, obs[k], {16'h0000, 5'b10001});
      end
    end
    issue(LOAD, 16'h8000);
    issue(SUB, 16'h0001);
    issue(ADD, 16'h0003);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== exp_vec(k, 1'b0, 1'b1)) begin
        tests_failed++;
        $display("FAIL sub_ovf_sticky dut%0d got %h expected %h", k, obs[k], exp_vec(k, 1'b0, 1'b1));
      end
    end
    $display("[TB] overflow checks done, sat=%h wrap=%h", data_s, data_w);
  endtask

  task automatic test_mac_basic();
    int bc, da, dc;
    issue(LOAD, 16'h000A);
    issue_mac(16'hFFFD, 16'h0007, bc, da, dc);
    tests_run++;
    if (bc != 17 || da != 17 || dc != 1) begin
      tests_failed++;
      $display("FAIL mac_timing busy=%0d done_at=%0d done_cnt=%0d expected 17/17/1", bc, da, dc);
    end
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== {16'hFFF5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL mac_basic dut%0d got %h expected %h", k, obs[k], {16'hFFF5, 5'b01000});
      end
    end
    $display("[TB] mac 10 + -3*7 -> %h", data_s);
  endtask

  task automatic test_mac_sat();
    int bc, da, dc;
    issue(LOAD, 16'h7000);
    issue_mac(16'h4000, 16'h4000, bc, da, dc);
    tests_run++;
    if (obs[0] !== {16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL mac_4000sq_sat got %h expected %h", obs[0], {16'h7FFF, 5'b00100});
    end
    tests_run++;
    if (obs[1] !== exp_vec(1, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL mac_4000sq_wrap got %h expected %h", obs[1], exp_vec(1, 1'b0, 1'b0));
    end
    issue(CLR, 16'h0000);
    issue_mac(16'h8000, 16'h8000, bc, da, dc);
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== exp_vec(k, 1'b0, 1'b0) || dc != 1) begin
        tests_failed++;
        $display("FAIL mac_minmin dut%0d got %h expected %h done_cnt=%0d", k, obs[k], exp_vec(k, 1'b0, 1'b0), dc);
      end
    end
    $display("[TB] mac saturation done, sat=%h wrap=%h", data_s, data_w);
  endtask

  task automatic test_busy_abort();
    int dc;
    issue(LOAD, 16'h1111);
    op = MAC; din = 16'h0100; coef = 16'h0100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    op = LOAD; din = 16'h5555; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (obs[0] !== exp_vec(0, 1'b1, 1'b0)) begin
      tests_failed++;
      $display("FAIL start_while_busy got %h expected %h", obs[0], exp_vec(0, 1'b1, 1'b0));
    end
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== exp_vec(k, 1'b0, 1'b0)) begin
        tests_failed++;
        $display("FAIL abort_mul dut%0d got %h expected %h", k, obs[k], exp_vec(k, 1'b0, 1'b0));
      end
    end
    dc = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (done_s || done_w) dc++;
    end
    tests_run++;
    if (dc != 0) begin
      tests_failed++;
      $display("FAIL abort_no_done got %0d done pulses expected 0", dc);
    end
    // abort sampled on the writeback edge wins over the writeback
    op = MAC; din = 16'h0002; coef = 16'h0003; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests_run++;
    if (obs[0] !== exp_vec(0, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL abort_accum got %h expected %h", obs[0], exp_vec(0, 1'b0, 1'b0));
    end
    abort = 1'b1;
    issue(LOAD, 16'h2222);
    abort = 1'b0;
    tests_run++;
    if (obs[0] !== exp_vec(0, 1'b0, 1'b1)) begin
      tests_failed++;
      $display("FAIL abort_idle_ignored got %h expected %h", obs[0], exp_vec(0, 1'b0, 1'b1));
    end
    $display("[TB] busy/abort checks done, data=%h", data_s);
  endtask

  task automatic test_reset_mid_mac();
    int dc;
    issue(LOAD, 16'h0777);
    op = MAC; din = 16'h0123; coef = 16'h0456; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 nreset = 1'b0;
    #1;
    m_reset();
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (obs[k] !== 21'h00010) begin
        tests_failed++;
        $display("FAIL async_reset dut%0d got %h expected %h", k, obs[k], 21'h00010);
      end
    end
    tick();
    nreset = 1'b1;
    dc = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (done_s || busy_s || data_s != 16'h0000) dc++;
    end
    tests_run++;
    if (dc != 0) begin
      tests_failed++;
      $display("FAIL reset_quiet got %0d bad cycles expected 0", dc);
    end
    issue(LOAD, 16'h0042);
    tests_run++;
    if (obs[0] !== {16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL load_after_reset got %h expected %h", obs[0], {16'h0042, 5'b00001});
    end
    $display("[TB] reset mid-mac done, data=%h", data_s);
  endtask

  task automatic test_random();
    int bc, da, dc;
    logic [2:0] o;
    logic [N-1:0] d, c;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: d = 16'h7FFF;
        1: d = 16'h8000;
        2: d = 16'(16'hFFF0 + $urandom_range(0, 31));
        default: d = 16'($urandom);
      endcase
      c = 16'($urandom);
      if (o == MAC) begin
        issue_mac(d, c, bc, da, dc);
        tests_run++;
        if (bc != 17 || da != 17 || dc != 1 || obs[0] !== exp_vec(0, 1'b0, 1'b0) || obs[1] !== exp_vec(1, 1'b0, 1'b0)) begin
          tests_failed++;
          $display("FAIL rand_mac %0d d=%h c=%h sat=%h wrap=%h expected %h/%h busy=%0d done_at=%0d", i, d, c,
                   obs[0], obs[1], exp_vec(0, 1'b0, 1'b0), exp_vec(1, 1'b0, 1'b0), bc, da);
        end
      end else begin
        issue(o, d);
        tests_run++;
        if (obs[0] !== exp_vec(0, 1'b0, 1'b1) || obs[1] !== exp_vec(1, 1'b0, 1'b1)) begin
          tests_failed++;
          $display("FAIL rand_op %0d op=%0d d=%h sat=%h wrap=%h expected %h/%h", i, o, d,
                   obs[0], obs[1], exp_vec(0, 1'b0, 1'b1), exp_vec(1, 1'b0, 1'b1));
        end
      end
      $display("[TB] rand %0d op=%0d d=%h c=%h -> sat=%h wrap=%h", i, o, d, c, data_s, data_w);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_mac_basic();
    test_mac_sat();
    test_busy_abort();
    test_reset_mid_mac();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
